// File: rtl/order_scheduler.sv
// order_scheduler: executes one parsed FTDI order as a burst of single-byte
// register-bus accesses, returns read bytes / write acknowledges to the TX FIFO,
// keeps one access outstanding and aborts any access that exceeds TIMEOUT.
//
// Handshakes: an order is taken on a cycle with cmd_valid & cmd_ready; a payload
// byte is taken on a cycle with wr_valid & wr_ready (wr_ready only rises while
// wr_valid is high); a bus access is rb_req held high until the rb_done pulse or
// the timeout, whichever comes first; a TX byte is pushed on a tx_write cycle,
// which never happens while tx_full is high.
module order_scheduler #(
  parameter int unsigned TIMEOUT  = 255,
  parameter logic [7:0]  ERR_FILL = 8'hEE
) (
  input  logic        clk,
  input  logic        res,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_header,
  input  logic [7:0]  cmd_address,
  input  logic [15:0] cmd_length,
  input  logic        wr_valid,
  input  logic [7:0]  wr_value,
  output logic        wr_ready,
  output logic        rb_req,
  output logic        rb_write,
  output logic [7:0]  rb_addr,
  output logic [7:0]  rb_wdata,
  input  logic [7:0]  rb_rdata,
  input  logic        rb_done,
  output logic [7:0]  tx_data,
  output logic        tx_write,
  input  logic        tx_full,
  output logic        err_timeout,
  input  logic        err_clear,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_WR_WAIT  = 3'd1,
    S_BUS      = 3'd2,
    S_RD_PUSH  = 3'd3,
    S_ACK_PUSH = 3'd4
  } state_t;

  // Last value of the wait counter before an access is abandoned; the counter
  // starts at 0, so rb_req stays up for exactly TIMEOUT cycles.
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  localparam logic [7:0] ACK_OK  = 8'hA5;
  localparam logic [7:0] ACK_ERR = 8'hE5;

  state_t      state_q, state_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [7:0]  addr_q, addr_d;
  logic [15:0] rem_q, rem_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rdata_q, rdata_d;
  logic [15:0] tmo_q, tmo_d;
  logic        err_q, err_d;
  logic        cmd_err_q, cmd_err_d;

  logic        hdr_write;
  logic        access_end;

  assign hdr_write  = hdr_q[0];
  assign access_end = rb_done || (tmo_q == TMO_LAST);

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q   <= S_IDLE;
      hdr_q     <= 8'h00;
      addr_q    <= 8'h00;
      rem_q     <= 16'h0000;
      wdata_q   <= 8'h00;
      rdata_q   <= 8'h00;
      tmo_q     <= 16'h0000;
      err_q     <= 1'b0;
      cmd_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hdr_q     <= hdr_d;
      addr_q    <= addr_d;
      rem_q     <= rem_d;
      wdata_q   <= wdata_d;
      rdata_q   <= rdata_d;
      tmo_q     <= tmo_d;
      err_q     <= err_d;
      cmd_err_q <= cmd_err_d;
    end
  end

  // Next-state and datapath update: order latch, access completion/abort, pushes.
  always_comb begin
    state_d   = state_q;
    hdr_d     = hdr_q;
    addr_d    = addr_q;
    rem_d     = rem_q;
    wdata_d   = wdata_q;
    rdata_d   = rdata_q;
    tmo_d     = tmo_q;
    err_d     = err_q;
    cmd_err_d = cmd_err_q;

    // A timeout later in this block overrides the clear.
    if (err_clear) err_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (cmd_valid && cmd_ready) begin
          hdr_d     = cmd_header;
          addr_d    = cmd_address;
          rem_d     = cmd_length;
          cmd_err_d = 1'b0;
          tmo_d     = 16'h0000;
          if (cmd_length == 16'h0000) begin
            state_d = (cmd_header[0] && cmd_header[7]) ? S_ACK_PUSH : S_IDLE;
          end else begin
            state_d = cmd_header[0] ? S_WR_WAIT : S_BUS;
          end
        end
      end
      S_WR_WAIT: begin
        if (wr_valid) begin
          wdata_d = wr_value;
          tmo_d   = 16'h0000;
          state_d = S_BUS;
        end
      end
      S_BUS: begin
        if (access_end) begin
          rem_d = rem_q - 16'd1;
          if (hdr_q[1]) addr_d = addr_q + 8'd1;
          // rb_done on the limit cycle still counts as a completed access.
          if (rb_done) begin
            if (!hdr_write) rdata_d = rb_rdata;
          end else begin
            err_d     = 1'b1;
            cmd_err_d = 1'b1;
            if (!hdr_write) rdata_d = ERR_FILL;
          end
          if (!hdr_write)            state_d = S_RD_PUSH;
          else if (rem_q != 16'd1)   state_d = S_WR_WAIT;
          else if (hdr_q[7])         state_d = S_ACK_PUSH;
          else                       state_d = S_IDLE;
        end else begin
          tmo_d = tmo_q + 16'd1;
        end
      end
      S_RD_PUSH: begin
        if (!tx_full) begin
          tmo_d   = 16'h0000;
          state_d = (rem_q != 16'h0000) ? S_BUS : S_IDLE;
        end
      end
      S_ACK_PUSH: begin
        if (!tx_full) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs decoded from the current state and registers.
  always_comb begin
    cmd_ready   = (state_q == S_IDLE) && !res;
    wr_ready    = (state_q == S_WR_WAIT) && wr_valid;
    rb_req      = (state_q == S_BUS);
    rb_write    = (state_q == S_BUS) && hdr_write;
    rb_addr     = addr_q;
    rb_wdata    = wdata_q;
    tx_write    = 1'b0;
    tx_data     = 8'h00;
    err_timeout = err_q;
    dbg_state   = state_q;
    case (state_q)
      S_RD_PUSH: begin
        tx_write = !tx_full;
        tx_data  = rdata_q;
      end
      S_ACK_PUSH: begin
        tx_write = !tx_full;
        tx_data  = cmd_err_q ? ACK_ERR : ACK_OK;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_order_scheduler.sv
// tb_order_scheduler: directed checks of order_scheduler with a bus responder,
// a payload driver, a bus/TX monitor and a TX expected-byte queue.
`timescale 1ns/1ps
module tb_order_scheduler;

  localparam int TMO = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic res = 1'b1;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [7:0]  cmd_header = 8'h00;
  logic [7:0]  cmd_address = 8'h00;
  logic [15:0] cmd_length = 16'h0000;
  logic        wr_valid = 1'b0;
  logic [7:0]  wr_value = 8'h00;
  logic        wr_ready;
  logic        rb_req;
  logic        rb_write;
  logic [7:0]  rb_addr;
  logic [7:0]  rb_wdata;
  logic [7:0]  rb_rdata = 8'h00;
  logic        rb_done = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_write;
  logic        tx_full = 1'b0;
  logic        err_timeout;
  logic        err_clear = 1'b0;
  logic [2:0]  dbg_state;

  order_scheduler #(.TIMEOUT(TMO), .ERR_FILL(8'hEE)) dut (
    .clk(clk), .res(res),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_header(cmd_header),
    .cmd_address(cmd_address), .cmd_length(cmd_length),
    .wr_valid(wr_valid), .wr_value(wr_value), .wr_ready(wr_ready),
    .rb_req(rb_req), .rb_write(rb_write), .rb_addr(rb_addr), .rb_wdata(rb_wdata),
    .rb_rdata(rb_rdata), .rb_done(rb_done),
    .tx_data(tx_data), .tx_write(tx_write), .tx_full(tx_full),
    .err_timeout(err_timeout), .err_clear(err_clear),
    .dbg_state(dbg_state)
  );

  // ---------------- checking ----------------
  int n_chk = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- bus responder ----------------
  // rb_done pulses resp_lat cycles after the first rb_req cycle; read data = address.
  logic resp_on = 1'b1;
  int   resp_lat = 2;
  int   wait_cnt = 0;
  always @(posedge clk) begin
    #1;
    rb_done = 1'b0;
    if (rb_req === 1'b1 && resp_on) begin
      if (wait_cnt == resp_lat) begin
        rb_done  = 1'b1;
        rb_rdata = rb_addr;
        wait_cnt = 0;
      end else begin
        wait_cnt++;
      end
    end else begin
      wait_cnt = 0;
    end
  end

  // ---------------- payload driver ----------------
  logic [7:0] pay_arr [4];
  int   pay_n = 0;
  int   pay_gen = 0;
  int   pay_seen = 0;
  int   pay_idx = 0;
  logic wr_took = 1'b0;
  always @(negedge clk) wr_took = (wr_ready === 1'b1);
  always @(posedge clk) begin
    #1;
    if (pay_gen != pay_seen) begin
      pay_seen = pay_gen;
      pay_idx  = 0;
    end else if (wr_took) begin
      pay_idx++;
    end
    wr_valid = (pay_idx < pay_n);
    wr_value = wr_valid ? pay_arr[pay_idx[1:0]] : 8'h00;
  end

  // ---------------- monitor ----------------
  logic [7:0] tx_got[$];
  int         tx_cyc[$];
  logic [7:0] addr_got[$];
  logic       wr_got[$];
  logic [7:0] wd_got[$];
  int         start_cyc[$];
  int         len_got[$];
  int         wr_cyc[$];
  int         clr_gen = 0;
  int         clr_seen = 0;
  int         stab_bad = 0;
  logic       in_req = 1'b0;
  int         run = 0;
  logic [7:0] h_addr = 8'h00;
  logic [7:0] h_wd = 8'h00;

  always @(negedge clk) begin
    if (clr_gen != clr_seen) begin
      clr_seen = clr_gen;
      tx_got.delete(); tx_cyc.delete(); addr_got.delete(); wr_got.delete();
      wd_got.delete(); start_cyc.delete(); len_got.delete(); wr_cyc.delete();
      stab_bad = 0;
    end
    if (tx_write === 1'b1) begin
      tx_got.push_back(tx_data);
      tx_cyc.push_back(cyc);
    end
    if (wr_ready === 1'b1) wr_cyc.push_back(cyc);
    if (rb_req === 1'b1 && !in_req) begin
      addr_got.push_back(rb_addr);
      wr_got.push_back(rb_write);
      wd_got.push_back(rb_wdata);
      start_cyc.push_back(cyc);
      h_addr = rb_addr;
      h_wd   = rb_wdata;
      run    = 0;
    end
    if (rb_req === 1'b1) begin
      run++;
      if (rb_addr !== h_addr || rb_wdata !== h_wd) stab_bad++;
    end else if (in_req) begin
      len_got.push_back(run);
    end
    in_req = (rb_req === 1'b1);
  end

  // ---------------- scoreboard ----------------
  logic [7:0] exp_q[$];

  task automatic compare_tx(input string tag);
    check_val({tag, "_tx_count"}, tx_got.size(), exp_q.size());
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < tx_got.size()) check_val({tag, "_tx_byte"}, tx_got[i], exp_q[i]);
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  int acc_cyc = 0;

  task automatic clear_mon();
    @(posedge clk); #1;
    clr_gen++;
    @(negedge clk);
  endtask

  task automatic load_payload(input logic [7:0] b0, input logic [7:0] b1, input int n);
    pay_arr[0] = b0;
    pay_arr[1] = b1;
    pay_n      = n;
    pay_gen++;
  endtask

  task automatic send_cmd(input logic [7:0] h, input logic [7:0] a, input logic [15:0] l);
    logic ok;
    ok = 1'b0;
    @(posedge clk); #1;
    cmd_valid   = 1'b1;
    cmd_header  = h;
    cmd_address = a;
    cmd_length  = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        acc_cyc = cyc;
        break;
      end
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    check_val("cmd_accept", ok, 1'b1);
  endtask

  task automatic wait_state(input string tag, input logic [2:0] s, input int budget);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (dbg_state === s) begin
        ok = 1'b1;
        break;
      end
    end
    check_val({tag, "_reached"}, ok, 1'b1);
  endtask

  // ---------------- stimulus ----------------
  int bad;
  int n_bus;
  int n_tx;
  logic seen;

  initial begin
    // Reset state, sampled while res is still high.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_val("rst_cmd_ready", cmd_ready, 1'b0);
    check_val("rst_ctrl", {rb_req, rb_write, tx_write, wr_ready, err_timeout}, 5'b0);
    check_val("rst_data", {rb_addr, rb_wdata, tx_data}, 24'h0);
    check_val("rst_state", dbg_state, 3'd0);
    @(posedge clk); #1;
    res = 1'b0;
    @(negedge clk);
    check_val("cmd_ready_after_rst", cmd_ready, 1'b1);

    // Read burst with auto-increment across the FF->00 wrap.
    clear_mon();
    resp_lat = 2;
    send_cmd(8'h02, 8'hFE, 16'd3);
    wait_state("rd_burst", 3'd0, 100);
    exp_q.push_back(8'hFE); exp_q.push_back(8'hFF); exp_q.push_back(8'h00);
    compare_tx("rd_burst");
    check_val("rd_bus_count", addr_got.size(), 3);
    if (addr_got.size() == 3) begin
      check_val("rd_addr0", addr_got[0], 8'hFE);
      check_val("rd_addr1", addr_got[1], 8'hFF);
      check_val("rd_addr2", addr_got[2], 8'h00);
      check_val("rd_is_read", {wr_got[0], wr_got[1], wr_got[2]}, 3'b000);
      check_val("rd_req_latency", start_cyc[0] - acc_cyc, 1);
      check_val("rd_req_spacing", start_cyc[1] - start_cyc[0], 4);
      check_val("rd_req_len", len_got[0], 3);
    end
    if (tx_cyc.size() > 0 && start_cyc.size() > 0)
      check_val("rd_tx_latency", tx_cyc[0] - start_cyc[0], 3);
    check_val("rd_addr_stable", stab_bad, 0);

    // Write burst with ack, fixed address.
    clear_mon();
    load_payload(8'h11, 8'h22, 2);
    send_cmd(8'h81, 8'h10, 16'd2);
    wait_state("wr_ack", 3'd0, 100);
    exp_q.push_back(8'hA5);
    compare_tx("wr_ack");
    check_val("wr_bus_count", addr_got.size(), 2);
    if (addr_got.size() == 2) begin
      check_val("wr_addr", {addr_got[0], addr_got[1]}, 16'h1010);
      check_val("wr_data", {wd_got[0], wd_got[1]}, 16'h1122);
      check_val("wr_is_write", {wr_got[0], wr_got[1]}, 2'b11);
    end
    if (wr_cyc.size() == 2 && start_cyc.size() > 0) begin
      check_val("wr_req_latency", start_cyc[0] - wr_cyc[0], 1);
      check_val("wr_next_ready", wr_cyc[1] - start_cyc[0], 3);
    end
    check_val("wr_data_stable", stab_bad, 0);
    check_val("wr_no_err", err_timeout, 1'b0);

    // rb_done on the last allowed cycle still completes the access.
    clear_mon();
    resp_lat = 3;
    send_cmd(8'h00, 8'h60, 16'd1);
    wait_state("edge_done", 3'd0, 100);
    exp_q.push_back(8'h60);
    compare_tx("edge_done");
    if (len_got.size() > 0) check_val("edge_req_len", len_got[0], TMO);
    check_val("edge_no_err", err_timeout, 1'b0);

    // Read timeout: rb_req up exactly TIMEOUT cycles, fill byte returned.
    clear_mon();
    resp_on = 1'b0;
    send_cmd(8'h00, 8'h33, 16'd1);
    wait_state("rd_tmo", 3'd0, 100);
    exp_q.push_back(8'hEE);
    compare_tx("rd_tmo");
    check_val("tmo_req_count", len_got.size(), 1);
    if (len_got.size() > 0) check_val("tmo_req_len", len_got[0], TMO);
    check_val("tmo_err_set", err_timeout, 1'b1);

    // Write timeout with ack request: error acknowledge.
    clear_mon();
    load_payload(8'h77, 8'h00, 1);
    send_cmd(8'h81, 8'h34, 16'd1);
    wait_state("wr_tmo", 3'd0, 100);
    exp_q.push_back(8'hE5);
    compare_tx("wr_tmo");
    repeat (3) @(negedge clk);
    check_val("tmo_err_sticky", err_timeout, 1'b1);
    @(posedge clk); #1;
    err_clear = 1'b1;
    @(posedge clk); #1;
    err_clear = 1'b0;
    @(negedge clk);
    check_val("tmo_err_cleared", err_timeout, 1'b0);
    resp_on  = 1'b1;
    resp_lat = 2;

    // TX backpressure: 10 stalled cycles in RD_PUSH, push on first non-full cycle.
    clear_mon();
    tx_full = 1'b1;
    send_cmd(8'h00, 8'h40, 16'd2);
    wait_state("bp_push", 3'd3, 50);
    bad = 0;
    repeat (10) begin
      @(negedge clk);
      if (tx_write !== 1'b0 || rb_req !== 1'b0 || dbg_state !== 3'd3) bad++;
    end
    check_val("bp_stall", bad, 0);
    @(posedge clk); #1;
    tx_full = 1'b0;
    @(negedge clk);
    check_val("bp_release_push", {tx_write, tx_data}, {1'b1, 8'h40});
    wait_state("bp_done", 3'd0, 100);
    exp_q.push_back(8'h40); exp_q.push_back(8'h40);
    compare_tx("bp");
    check_val("bp_bus_count", addr_got.size(), 2);

    // Zero-length read: no activity at all.
    clear_mon();
    send_cmd(8'h00, 8'h12, 16'd0);
    repeat (4) @(negedge clk);
    check_val("z_rd_bus", addr_got.size(), 0);
    check_val("z_rd_tx", tx_got.size(), 0);
    check_val("z_rd_idle", dbg_state, 3'd0);

    // Zero-length write with ack: A5 only.
    clear_mon();
    send_cmd(8'h81, 8'h12, 16'd0);
    wait_state("z_wr", 3'd0, 20);
    repeat (2) @(negedge clk);
    exp_q.push_back(8'hA5);
    compare_tx("z_wr");
    check_val("z_wr_bus", addr_got.size(), 0);

    // Reset during the second access of a 5-byte read.
    clear_mon();
    send_cmd(8'h02, 8'h80, 16'd5);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (rb_req === 1'b1 && rb_addr === 8'h81) begin
        seen = 1'b1;
        break;
      end
    end
    check_val("rst_mid_reached", seen, 1'b1);
    @(posedge clk); #1;
    res = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    check_val("rst_mid_ctrl", {rb_req, tx_write, cmd_ready}, 3'b000);
    check_val("rst_mid_addr", rb_addr, 8'h00);
    check_val("rst_mid_state", dbg_state, 3'd0);
    n_bus = addr_got.size();
    n_tx  = tx_got.size();
    @(posedge clk); #1;
    res = 1'b0;
    repeat (6) @(negedge clk);
    check_val("rst_mid_no_bus", addr_got.size(), n_bus);
    check_val("rst_mid_no_tx", tx_got.size(), n_tx);

    clear_mon();
    send_cmd(8'h00, 8'h55, 16'd1);
    wait_state("post_rst", 3'd0, 100);
    exp_q.push_back(8'h55);
    compare_tx("post_rst");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  // Hard stop in case a wait path is ever broken.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
